// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU codes,
// FSM states, decode classes and the ALU-B select values.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;

  // R-type extension codes; the same values appear in OpCode for I-type.
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;
  localparam logic [3:0] EXT_LSH  = 4'h4;
  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;

  // Code 0 is left unused so an idle ALU control is never a real operation.
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_SUB   = 4'h2;
  localparam logic [3:0] ALU_RSUB  = 4'h3;
  localparam logic [3:0] ALU_AND   = 4'h4;
  localparam logic [3:0] ALU_OR    = 4'h5;
  localparam logic [3:0] ALU_XOR   = 4'h6;
  localparam logic [3:0] ALU_CMP   = 4'h7;
  localparam logic [3:0] ALU_RCMP  = 4'h8;
  localparam logic [3:0] ALU_PASSA = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  localparam logic [1:0] MUX4_DST  = 2'd0;
  localparam logic [1:0] MUX4_SIGN = 2'd1;
  localparam logic [1:0] MUX4_ONE  = 2'd2;
  localparam logic [1:0] MUX4_ZERO = 2'd3;

  localparam logic [1:0] CTL_OFF = 2'b00;
  localparam logic [1:0] CTL_ON  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_ALU,
    S_EXEC_SHIFT, S_MEM_LOAD, S_MEM_STORE, S_WB
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_RTYPE, CL_ITYPE, CL_SHIFT, CL_LOAD, CL_STORE
  } class_t;

  function automatic logic [1:0] ctl(input logic b);
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class, ALU code and immediate
// sign-extension choice for the latched OpCode/OpCodeExt.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [3:0] i_ext,
  output class_t     o_class,
  output logic [3:0] o_alu,
  output logic       o_sign_en,
  output logic       o_is_cmp,
  output logic       o_is_imm_shift
);

  logic       w_itype;
  logic [3:0] w_alu_op;
  class_t     w_alu_class;

  // R-type carries the operation in ext; I-type carries it in the opcode.
  assign w_itype     = (i_opcode != OP_RTYPE);
  assign w_alu_op    = w_itype ? i_opcode : i_ext;
  assign w_alu_class = w_itype ? CL_ITYPE : CL_RTYPE;

  always_comb begin
    o_class        = CL_ILLEGAL;
    o_alu          = 4'h0;
    o_sign_en      = 1'b0;
    o_is_cmp       = 1'b0;
    o_is_imm_shift = 1'b0;
    case (i_opcode)
      OP_SHIFT: begin
        if (i_ext == EXT_LSH) begin
          o_class = CL_SHIFT;
        end else if (i_ext[3:1] == 3'b000) begin
          o_class        = CL_SHIFT;
          o_is_imm_shift = 1'b1;
        end
      end
      OP_MEM: begin
        if (i_ext == EXT_LOAD)      o_class = CL_LOAD;
        else if (i_ext == EXT_STOR) o_class = CL_STORE;
      end
      default: begin
        case (w_alu_op)
          EXT_ADD: begin
            o_class = w_alu_class; o_alu = ALU_ADD; o_sign_en = w_itype;
          end
          EXT_SUB: begin
            o_class = w_alu_class; o_sign_en = w_itype;
            o_alu   = w_itype ? ALU_SUB : ALU_RSUB;
          end
          EXT_CMP: begin
            o_class = w_alu_class; o_sign_en = w_itype; o_is_cmp = 1'b1;
            o_alu   = w_itype ? ALU_CMP : ALU_RCMP;
          end
          EXT_AND: begin o_class = w_alu_class; o_alu = ALU_AND; end
          EXT_OR:  begin o_class = w_alu_class; o_alu = ALU_OR;  end
          EXT_XOR: begin o_class = w_alu_class; o_alu = ALU_XOR; end
          EXT_MOV: begin
            o_class = w_alu_class;
            o_alu   = w_itype ? ALU_PASSB : ALU_PASSA;
          end
          default: o_class = CL_ILLEGAL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle controller for the 16-bit datapath: fetch, decode, execute,
// memory and writeback sequencing of the datapath control inputs.
module control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        memReady,
  output logic        memRead,
  output logic        memWrite,
  output logic        addrSel,
  output logic        irLoad,
  output logic        flagEn,
  output logic        illegalOp,
  output logic [3:0]  aluControl,
  output logic [1:0]  mux4En,
  output logic [1:0]  srcFieldSel,
  output logic [1:0]  pcRegEn,
  output logic [1:0]  srcRegEn,
  output logic [1:0]  dstRegEn,
  output logic [1:0]  immRegEn,
  output logic [1:0]  resultRegEn,
  output logic [1:0]  signEn,
  output logic [1:0]  regFileEn,
  output logic [1:0]  pcRegMuxEn,
  output logic [1:0]  shiftALUMuxEn,
  output logic [1:0]  regImmMuxEn,
  output logic [1:0]  exMemResultEn,
  output state_t      o_dbg_state
);

  state_t     r_state;
  state_t     w_next;
  logic       r_run;
  logic [3:0] r_opcode;
  logic [3:0] r_ext;
  logic       r_illegal;
  class_t     w_class;
  logic [3:0] w_alu;
  logic       w_sign_en;
  logic       w_is_cmp;
  logic       w_is_imm_shift;
  logic       w_fetch_done;
  logic       w_unused_fields;

  // Register and immediate fields go straight to the datapath, not here.
  assign w_unused_fields = ^{instruction[11:8], instruction[3:0]};

  ctrl_decode u_decode (
    .i_opcode       (r_opcode),
    .i_ext          (r_ext),
    .o_class        (w_class),
    .o_alu          (w_alu),
    .o_sign_en      (w_sign_en),
    .o_is_cmp       (w_is_cmp),
    .o_is_imm_shift (w_is_imm_shift)
  );

  assign w_fetch_done = (r_state == S_FETCH) && memReady;
  assign irLoad       = w_fetch_done;
  assign illegalOp    = r_illegal;
  assign o_dbg_state  = r_state;

  // r_run holds IDLE for one full cycle after reset release, so the first
  // FETCH lands on the second rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b0;
      r_opcode  <= 4'h0;
      r_ext     <= 4'h0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (w_fetch_done) begin
        r_opcode <= instruction[15:12];
        r_ext    <= instruction[7:4];
      end
      if (r_state == S_DECODE && w_class == CL_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  // Memory handshake: memRead/memWrite are the request (valid) and memReady
  // the completion (ready); request and addrSel stay stable until memReady.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_run) w_next = S_FETCH;
      S_FETCH:  if (memReady) w_next = S_DECODE;
      S_DECODE: begin
        case (w_class)
          CL_RTYPE, CL_ITYPE: w_next = S_EXEC_ALU;
          CL_SHIFT:           w_next = S_EXEC_SHIFT;
          CL_LOAD:            w_next = S_MEM_LOAD;
          CL_STORE:           w_next = S_MEM_STORE;
          default:            w_next = S_FETCH;
        endcase
      end
      S_EXEC_ALU:   w_next = w_is_cmp ? S_FETCH : S_WB;
      S_EXEC_SHIFT: w_next = S_WB;
      S_MEM_LOAD:   if (memReady) w_next = S_WB;
      S_MEM_STORE:  if (memReady) w_next = S_FETCH;
      S_WB:         w_next = S_FETCH;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    memRead       = 1'b0;
    memWrite      = 1'b0;
    addrSel       = 1'b0;
    flagEn        = 1'b0;
    aluControl    = 4'h0;
    mux4En        = MUX4_DST;
    srcFieldSel   = CTL_OFF;
    pcRegEn       = CTL_OFF;
    srcRegEn      = CTL_OFF;
    dstRegEn      = CTL_OFF;
    immRegEn      = CTL_OFF;
    resultRegEn   = CTL_OFF;
    signEn        = CTL_OFF;
    regFileEn     = CTL_OFF;
    pcRegMuxEn    = CTL_OFF;
    shiftALUMuxEn = CTL_OFF;
    regImmMuxEn   = CTL_OFF;
    exMemResultEn = CTL_OFF;
    case (r_state)
      S_FETCH: memRead = 1'b1;
      S_DECODE: begin
        srcRegEn    = CTL_ON;
        dstRegEn    = CTL_ON;
        immRegEn    = CTL_ON;
        pcRegEn     = CTL_ON;
        mux4En      = MUX4_ONE;
        aluControl  = ALU_ADD;
        srcFieldSel = ctl(w_class == CL_ITYPE);
      end
      S_EXEC_ALU: begin
        pcRegMuxEn = CTL_ON;
        mux4En     = (w_class == CL_ITYPE) ? MUX4_SIGN : MUX4_DST;
        aluControl = w_alu;
        signEn     = ctl(w_sign_en);
        flagEn     = w_is_cmp;
        resultRegEn = ctl(!w_is_cmp);
      end
      S_EXEC_SHIFT: begin
        shiftALUMuxEn = CTL_ON;
        resultRegEn   = CTL_ON;
        regImmMuxEn   = ctl(w_is_imm_shift);
        signEn        = ctl(w_is_imm_shift);
      end
      S_MEM_LOAD: begin
        memRead = 1'b1;
        addrSel = 1'b1;
      end
      S_MEM_STORE: begin
        memWrite = 1'b1;
        addrSel  = 1'b1;
      end
      S_WB: begin
        regFileEn     = CTL_ON;
        exMemResultEn = ctl(w_class == CL_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: table-driven instructions, randomized instruction
// stream and reset corner cases, checked cycle by cycle against a trace model.
module tb_control_fsm;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_read, mem_write, addr_sel, ir_load, flag_en, illegal;
    logic [3:0] alu;
    logic [1:0] mux4;
    logic [1:0] src_field, pc_reg, src_reg, dst_reg, imm_reg, result_reg;
    logic [1:0] sign, reg_file, pc_mux, shift_mux, reg_imm_mux, ex_mem;
  } outs_t;

  localparam int OW = $bits(outs_t);
  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LSH = 3, K_LSHI = 4, K_LOAD = 5, K_STOR = 6;

  typedef struct {
    logic [15:0] ins;
    int          fw;
    int          mw;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        memReady;
  logic        memRead, memWrite, addrSel, irLoad, flagEn, illegalOp;
  logic [3:0]  aluControl;
  logic [1:0]  mux4En, srcFieldSel, pcRegEn, srcRegEn, dstRegEn, immRegEn;
  logic [1:0]  resultRegEn, signEn, regFileEn, pcRegMuxEn, shiftALUMuxEn;
  logic [1:0]  regImmMuxEn, exMemResultEn;
  state_t      dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic m_illegal = 1'b0;

  logic [OW-1:0] exp_q[$];
  logic [16:0]   drv_q[$];
  vec_t          tbl[$];

  logic [3:0] k_codes [7] = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
  logic [3:0] r_alu   [7] = '{ALU_ADD, ALU_RSUB, ALU_RCMP, ALU_AND, ALU_OR, ALU_XOR, ALU_PASSA};
  logic [3:0] i_alu   [7] = '{ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR, ALU_PASSB};
  logic       i_sign  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction), .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .addrSel(addrSel), .irLoad(irLoad),
    .flagEn(flagEn), .illegalOp(illegalOp), .aluControl(aluControl),
    .mux4En(mux4En), .srcFieldSel(srcFieldSel), .pcRegEn(pcRegEn),
    .srcRegEn(srcRegEn), .dstRegEn(dstRegEn), .immRegEn(immRegEn),
    .resultRegEn(resultRegEn), .signEn(signEn), .regFileEn(regFileEn),
    .pcRegMuxEn(pcRegMuxEn), .shiftALUMuxEn(shiftALUMuxEn),
    .regImmMuxEn(regImmMuxEn), .exMemResultEn(exMemResultEn),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic outs_t sample();
    outs_t s;
    s.mem_read = memRead;   s.mem_write = memWrite; s.addr_sel = addrSel;
    s.ir_load  = irLoad;    s.flag_en   = flagEn;   s.illegal  = illegalOp;
    s.alu      = aluControl; s.mux4     = mux4En;
    s.src_field = srcFieldSel; s.pc_reg = pcRegEn; s.src_reg = srcRegEn;
    s.dst_reg  = dstRegEn;  s.imm_reg   = immRegEn; s.result_reg = resultRegEn;
    s.sign     = signEn;    s.reg_file  = regFileEn; s.pc_mux = pcRegMuxEn;
    s.shift_mux = shiftALUMuxEn; s.reg_imm_mux = regImmMuxEn; s.ex_mem = exMemResultEn;
    return s;
  endfunction

  function automatic int find_code(input logic [3:0] c);
    for (int i = 0; i < 7; i++) if (k_codes[i] == c) return i;
    return -1;
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input int fw, input int mw, input int lat);
    vec_t v;
    v.ins = ins; v.fw = fw; v.mw = mw; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] ins, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s instr=%h t=%0t got=%h exp=%h", name, ins, $time, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic mr, input logic [15:0] ins, output outs_t got);
    @(posedge clk);
    #1;
    memReady    = mr;
    instruction = ins;
    #3;
    got = sample();
  endtask

  task automatic push(input logic mr, input logic [15:0] ins, input outs_t o);
    o.illegal = m_illegal;
    drv_q.push_back({mr, ins});
    exp_q.push_back(o);
  endtask

  // ---------------- reference model ----------------
  // Expands one instruction into the per-cycle list of expected controls,
  // following the phase rules: fetch, decode, then the class-specific phases.
  task automatic build(input logic [15:0] ins, input int fw, input int mw);
    logic [3:0] op, ex;
    int kind, idx;
    outs_t o;
    op = ins[15:12]; ex = ins[7:4]; idx = -1;
    if (op == 4'h0 && find_code(ex) >= 0) begin kind = K_R; idx = find_code(ex); end
    else if (find_code(op) >= 0)          begin kind = K_I; idx = find_code(op); end
    else if (op == 4'h8 && ex == 4'h4)        kind = K_LSH;
    else if (op == 4'h8 && ex[3:1] == 3'b000) kind = K_LSHI;
    else if (op == 4'h4 && ex == 4'h0)        kind = K_LOAD;
    else if (op == 4'h4 && ex == 4'h4)        kind = K_STOR;
    else                                      kind = K_ILL;

    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_read = 1'b1;
      push(1'b0, 16'($urandom), o);
    end
    o = '0; o.mem_read = 1'b1; o.ir_load = 1'b1;
    push(1'b1, ins, o);

    o = '0;
    o.src_reg = 2'b01; o.dst_reg = 2'b01; o.imm_reg = 2'b01; o.pc_reg = 2'b01;
    o.mux4 = 2'd2; o.alu = ALU_ADD;
    o.src_field = (kind == K_I) ? 2'b01 : 2'b00;
    push(1'($urandom_range(0, 1)), 16'($urandom), o);

    o = '0;
    case (kind)
      K_ILL: m_illegal = 1'b1;
      K_R, K_I: begin
        o.pc_mux = 2'b01;
        o.mux4   = (kind == K_I) ? 2'd1 : 2'd0;
        o.alu    = (kind == K_I) ? i_alu[idx] : r_alu[idx];
        o.sign   = (kind == K_I && i_sign[idx]) ? 2'b01 : 2'b00;
        if (idx == 2) o.flag_en = 1'b1;
        else          o.result_reg = 2'b01;
        push(1'($urandom_range(0, 1)), 16'($urandom), o);
        if (idx != 2) begin
          o = '0; o.reg_file = 2'b01;
          push(1'($urandom_range(0, 1)), 16'($urandom), o);
        end
      end
      K_LSH, K_LSHI: begin
        o.shift_mux = 2'b01; o.result_reg = 2'b01;
        o.reg_imm_mux = (kind == K_LSHI) ? 2'b01 : 2'b00;
        o.sign        = (kind == K_LSHI) ? 2'b01 : 2'b00;
        push(1'($urandom_range(0, 1)), 16'($urandom), o);
        o = '0; o.reg_file = 2'b01;
        push(1'($urandom_range(0, 1)), 16'($urandom), o);
      end
      K_LOAD: begin
        o.mem_read = 1'b1; o.addr_sel = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, 16'($urandom), o);
        push(1'b1, 16'($urandom), o);
        o = '0; o.reg_file = 2'b01; o.ex_mem = 2'b01;
        push(1'($urandom_range(0, 1)), 16'($urandom), o);
      end
      default: begin
        o.mem_write = 1'b1; o.addr_sel = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, 16'($urandom), o);
        push(1'b1, 16'($urandom), o);
      end
    endcase
  endtask

  // ---------------- scoreboard replay ----------------
  task automatic run_trace(input int limit, inout int n, inout int irl, inout int meas);
    logic [16:0] d;
    outs_t e, got;
    while (exp_q.size() > 0 && n < limit) begin
      d = drv_q.pop_front();
      e = exp_q.pop_front();
      step(d[16], d[15:0], got);
      check("trace", d[15:0], got, e);
      if (got.ir_load && irl < 0) irl = n;
      else if (irl >= 0 && meas < 0 && got.mem_read && !got.addr_sel) meas = n;
      n++;
    end
  endtask

  task automatic run_entry(input vec_t v);
    int n, irl, meas, lat;
    outs_t got, e;
    n = 0; irl = -1; meas = -1;
    build(v.ins, v.fw, v.mw);
    run_trace(1000, n, irl, meas);
    e = '0; e.mem_read = 1'b1; e.illegal = m_illegal;
    step(1'b0, 16'($urandom), got);
    check("next_fetch", v.ins, got, e);
    if (irl >= 0 && meas < 0 && got.mem_read && !got.addr_sel) meas = n;
    lat = (irl >= 0 && meas >= 0) ? meas - irl : -1;
    if (v.lat > 0) begin
      n_checks++;
      if (lat != v.lat) begin
        n_err++;
        $display("FAIL latency instr=%h got=%0d exp=%0d", v.ins, lat, v.lat);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    outs_t got;
    logic [15:0] ins;
    int sel, dummy_n, dummy_i, dummy_m;

    reset = 1'b0; memReady = 1'b1; instruction = 16'h0352;
    repeat (2) @(posedge clk);
    #3;
    check("reset_outs", instruction, sample(), '0);
    @(posedge clk); #1; reset = 1'b1;
    step(1'b1, 16'h0352, got);
    check("idle_cycle", 16'h0352, got, '0);

    tbl.push_back(mk(16'h0352, 0, 0, 4));  // ADD R3,R2
    tbl.push_back(mk(16'h54FD, 0, 0, 4));  // ADDI R4,#-3
    tbl.push_back(mk(16'h4106, 1, 2, 6));  // LOAD with two wait cycles
    tbl.push_back(mk(16'h4246, 0, 0, 3));  // STOR
    tbl.push_back(mk(16'h4546, 2, 1, 4));  // STOR with one wait
    tbl.push_back(mk(16'h4706, 0, 0, 4));  // LOAD zero-wait
    tbl.push_back(mk(16'h02B1, 0, 0, 3));  // CMP
    tbl.push_back(mk(16'hB20A, 0, 0, 3));  // CMPI
    tbl.push_back(mk(16'h8143, 0, 0, 4));  // LSH
    tbl.push_back(mk(16'h8213, 0, 0, 4));  // LSHI ext 0001
    tbl.push_back(mk(16'h8A05, 0, 0, 4));  // LSHI ext 0000
    tbl.push_back(mk(16'h01D2, 0, 0, 4));  // MOV
    tbl.push_back(mk(16'hD1FF, 0, 0, 4));  // MOVI
    tbl.push_back(mk(16'h0192, 0, 0, 4));  // SUB
    tbl.push_back(mk(16'h1307, 0, 0, 4));  // ANDI
    tbl.push_back(mk(16'h0431, 0, 0, 4));  // XOR
    tbl.push_back(mk(16'h2A55, 0, 0, 4));  // ORI
    tbl.push_back(mk(16'hF000, 0, 0, 2));  // illegal opcode
    tbl.push_back(mk(16'h0000, 0, 0, 2));  // R-type with unknown ext
    tbl.push_back(mk(16'h4F16, 0, 0, 2));  // memory with unknown ext
    tbl.push_back(mk(16'h8F53, 0, 0, 2));  // shift with unknown ext
    tbl.push_back(mk(16'h0352, 0, 0, 4));  // ADD after illegal: flag stays set
    foreach (tbl[i]) run_entry(tbl[i]);

    // randomized stream; illegalOp stays sticky throughout
    for (int i = 0; i < 120; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        1: ins = {4'h0, 4'($urandom), k_codes[$urandom_range(0, 6)], 4'($urandom)};
        2: ins = {k_codes[$urandom_range(0, 6)], 12'($urandom)};
        3: ins = {4'h8, 4'($urandom), ($urandom_range(0, 1) == 1) ? 4'h4 : {3'b000, 1'($urandom)}, 4'($urandom)};
        4: ins = {4'h4, 4'($urandom), ($urandom_range(0, 1) == 1) ? 4'h4 : 4'h0, 4'($urandom)};
        default: ins = 16'($urandom);
      endcase
      run_entry(mk(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1));
    end

    // reset asserted while MEM_LOAD waits: outputs drop without a clock edge
    dummy_n = 0; dummy_i = -1; dummy_m = -1;
    build(16'h4106, 0, 5);
    run_trace(3, dummy_n, dummy_i, dummy_m);
    drv_q.delete(); exp_q.delete();
    #1; reset = 1'b0;
    #1;
    check("async_reset", 16'h4106, sample(), '0);
    m_illegal = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    step(1'b1, 16'h4106, got);
    check("idle_after_reset", 16'h4106, got, '0);
    run_entry(mk(16'h0352, 0, 0, 4));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
